// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: bundles the two write requesters (A: writeback, B:
// multi-cycle unit) and the register-file write port driven by the arbiter.
//   master : requester / register-file side (drives a_*/b_* requests)
//   slave  : the arbiter (drives ready flags, write port, status)
// Signals:
//   a_valid/a_ready/a_reg/a_data  A write request handshake
//   b_valid/b_ready/b_reg/b_data  B write request handshake (buffered)
//   reg_write/write_reg/write_data register-file write port
//   b_count                       B FIFO occupancy
//   starved                       forced-B cycle (A stalled)
interface rf_write_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [4:0]    a_reg;
    logic [31:0]   a_data;
    logic          b_valid;
    logic          b_ready;
    logic [4:0]    b_reg;
    logic [31:0]   b_data;
    logic          reg_write;
    logic [4:0]    write_reg;
    logic [31:0]   write_data;
    logic [CW-1:0] b_count;
    logic          starved;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, reg_write, write_reg, write_data, b_count, starved
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, reg_write, write_reg, write_data, b_count, starved
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between
// requester A (priority) and requester B (buffered in an in-order FIFO).
// A starvation counter stalls A for one cycle after STARVE_LIMIT consecutive
// A grants while B is pending, letting one B entry through.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  rf_write_arbiter_if.slave (requests, ready flags, write port, status)
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_fifo_reg  [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_reg_write;
    logic [4:0]    r_write_reg;
    logic [31:0]   r_write_data;

    logic w_b_ready;
    logic w_b_nonempty;
    logic w_force_b;
    logic w_grant_a;
    logic w_pop;
    logic w_push;

    // Ready/force depend only on registered state, so a same-cycle pop never
    // frees a slot for a same-cycle push.
    assign w_b_ready    = (r_count != CW'(DEPTH));
    assign w_b_nonempty = (r_count != '0);
    assign w_force_b    = (r_starve == SW'(STARVE_LIMIT)) && w_b_nonempty;
    // A write to r0 completes its handshake but never uses the port.
    assign w_grant_a    = bus.a_valid && !w_force_b && (bus.a_reg != 5'd0);
    assign w_pop        = w_b_nonempty && !w_grant_a;
    assign w_push       = bus.b_valid && w_b_ready && (bus.b_reg != 5'd0);

    assign bus.a_ready    = !w_force_b;
    assign bus.starved    = w_force_b;
    assign bus.b_ready    = w_b_ready;
    assign bus.b_count    = r_count;
    assign bus.reg_write  = r_reg_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;

    // FIFO storage needs no reset: occupancy and pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= bus.b_reg;
            r_fifo_data[r_wr_ptr] <= bus.b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop || !w_b_nonempty)
                r_starve <= '0;
            else if (w_grant_a && (r_starve != SW'(STARVE_LIMIT)))
                r_starve <= r_starve + 1'b1;

            // write_reg/write_data hold their last value on idle cycles.
            if (w_grant_a) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= bus.a_reg;
                r_write_data <= bus.a_data;
            end else if (w_pop) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= r_fifo_reg[r_rd_ptr];
                r_write_data <= r_fifo_data[r_rd_ptr];
            end else begin
                r_reg_write  <= 1'b0;
            end
        end
    end
endmodule
